pulse_train_scheduler: RTL and testbench
========================================

Name: pulse_train_scheduler

Overview:
- Round-robin scheduler that shares one pulse-generation resource between NUM_REQ requesters.
- Each requester asks for a pulse train described by high width, low gap and pulse count.
- On grant, the block latches the winner's configuration and drives `pulse_o` through the full train.
- It signals completion to the owner, then re-arbitrates. Sits between control logic and the shared pulse output pin/net.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- CNT_W, 8, width of each width/gap/count field.
- Derived: IDW = $clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-requester request level.
- width_i  in  NUM_REQ*CNT_W  high cycles per pulse; requester r uses bits [r*CNT_W +: CNT_W].
- gap_i  in  NUM_REQ*CNT_W  low cycles between pulses, same slicing.
- count_i  in  NUM_REQ*CNT_W  pulses in train, same slicing.
- gnt_o  out  NUM_REQ  one-hot, registered, one-cycle grant.
- owner_o  out  IDW  index of current/last granted requester.
- busy_o  out  1  train in progress.
- pulse_o  out  1  shared pulse output, registered.
- done_o  out  NUM_REQ  one-hot, one-cycle train-complete strobe.

Behaviour:
- Clock and reset: one clock `clk`; reset `rstn` is asynchronous, active-low.
- Reset values: state=IDLE, `pulse_o`=0, `gnt_o`=0, `done_o`=0, `busy_o`=0, `owner_o`=0, round-robin pointer=0, all counters 0.
- Reset mid-train: asserting `rstn` forces all outputs low immediately. The train is abandoned with no `done_o`. A request still held after release is arbitrated normally.
- States: IDLE, HIGH, LOW.
- IDLE, any `req_i` bit set at edge:
  - The winner is the first set bit searching upward from the pointer, with wrap-around.
  - Winner's width/gap/count are latched; the pointer becomes (winner+1) mod NUM_REQ.
  - Next cycle (call it cycle 0): `gnt_o[winner]`=1, `owner_o`=winner, `busy_o`=1, `pulse_o`=1, state=HIGH.
- Zero-value handling: latched width 0 is treated as 1; gap 0 is treated as 1.
- Count 0: cycle 0 has `gnt_o`=1, `busy_o`=1, `pulse_o`=0. Cycle 1 has `done_o[winner]`=1 and state IDLE.
- HIGH: `pulse_o`=1 for exactly W cycles.
  - After the last high cycle, if pulses remain → LOW.
  - Otherwise → IDLE, with `done_o[owner]`=1, `busy_o`=0, `pulse_o`=0 in that first IDLE cycle.
- LOW: `pulse_o`=0 for exactly G cycles, then → HIGH. No trailing gap after the final pulse.
- Train length: count C>0 occupies C*W+(C-1)*G cycles from cycle 0 (busy). `done_o` falls in the following cycle.
- Re-arbitration: evaluated at the edge ending the `done_o` cycle, so there is a minimum one-cycle idle gap between trains.
- Requester protocol:
  - Hold `req_i` until `gnt_o`; drop it in the `gnt_o` cycle.
  - `req_i` still high at the next IDLE edge is a new request.
  - Withdrawing `req_i` before grant cancels it silently.
- Configuration: inputs are sampled only at the granting edge; changes during a train are ignored. `req_i` activity during HIGH/LOW is ignored.
- `owner_o` holds its value after completion until the next grant.
- `gnt_o` and `done_o` are never asserted in the same cycle. `gnt_o` and `done_o` are never multi-hot.
- Counters are CNT_W bits, count down, and do not wrap. Count = 2^CNT_W−1 must complete correctly.

Test Plan:
- Single train: req 0, W=2, G=3, C=3. Expect `pulse_o` high in cycles 0-1, 5-6, 10-11 and low in 2-4, 7-9. `busy_o` high cycles 0-11; `done_o`=4'b0001 in cycle 12; `gnt_o`=4'b0001 only in cycle 0.
- Contention: all four requests raised in the same cycle, each W=1, C=1, each dropping req on grant. Expect grants to 0,1,2,3 at cycles 0,2,4,6, each `done_o` one cycle after its grant, and `owner_o` tracking.
- Fairness: `req_i[0]` and `req_i[2]` re-raised continuously. Expect grant sequence 0,2,0,2,… and never two consecutive grants to the same requester.
- Zero fields: C=0 → `gnt_o` cycle 0, `pulse_o` never high, `done_o` cycle 1. W=0, G=0, C=2 → `pulse_o` pattern 1,0,1, then `done_o`.
- Config stability: change `width_i`/`count_i` of the owner mid-train. Expect the train to be unchanged from the latched values.
- Reset mid-train: drop `rstn` asynchronously during HIGH of a W=5 train. Expect `pulse_o`/`busy_o`/`gnt_o` 0 immediately and no `done_o`. With req 1 held after release, it is granted first (pointer reset to 0, req 1 the only requester).

Source files
------------

// File: rtl/pulse_train_scheduler.sv
// Round-robin scheduler sharing one pulse-train generator between NUM_REQ requesters.
// The winner's width/gap/count are latched at grant; all outputs are registered.
module pulse_train_scheduler #(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 8,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*CNT_W-1:0] width_i,
    input  logic [NUM_REQ*CNT_W-1:0] gap_i,
    input  logic [NUM_REQ*CNT_W-1:0] count_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [IDW-1:0]           owner_o,
    output logic                     busy_o,
    output logic                     pulse_o,
    output logic [NUM_REQ-1:0]       done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]   ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   ZERO_C = CNT_W'(0);
    localparam logic [NUM_REQ-1:0] BIT0_C = NUM_REQ'(1);

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     phase_r, phase_s;
    logic [CNT_W-1:0]     left_r,  left_s;
    logic [CNT_W-1:0]     wid_r,   wid_s;
    logic [CNT_W-1:0]     gap_r,   gap_s;
    logic [IDW-1:0]       ptr_r,   ptr_s;
    logic [IDW-1:0]       owner_r, owner_s;
    logic [NUM_REQ-1:0]   gnt_r,   gnt_s;
    logic [NUM_REQ-1:0]   done_r,  done_s;
    logic                 busy_r,  busy_s;
    logic                 pulse_r, pulse_s;

    logic                 found_s;
    logic [IDW-1:0]       win_s;
    logic [IDW:0]         idx_s;
    logic [CNT_W-1:0]     win_w_s;
    logic [CNT_W-1:0]     win_g_s;
    logic [CNT_W-1:0]     win_c_s;

    // Zero-length high/low phases still last one cycle.
    function automatic logic [CNT_W-1:0] nz_len(input logic [CNT_W-1:0] v);
        nz_len = (v == ZERO_C) ? ONE_C : v;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
        onehot = BIT0_C << idx;
    endfunction

    // Round-robin search: first set request at or above the pointer, wrapping.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = {1'b0, ptr_r} + (IDW+1)'(i);
            if (idx_s >= (IDW+1)'(NUM_REQ)) begin
                idx_s = idx_s - (IDW+1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_i[idx_s[IDW-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Winner's configuration slices.
    always_comb begin
        win_w_s = width_i[int'(win_s)*CNT_W +: CNT_W];
        win_g_s = gap_i[int'(win_s)*CNT_W +: CNT_W];
        win_c_s = count_i[int'(win_s)*CNT_W +: CNT_W];
    end

    // Next-state and next-output logic for the train sequencer.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        left_s  = left_r;
        wid_s   = wid_r;
        gap_s   = gap_r;
        ptr_s   = ptr_r;
        owner_s = owner_r;
        gnt_s   = '0;
        done_s  = '0;
        busy_s  = busy_r;
        pulse_s = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (found_s) begin
                    state_s = HIGH;
                    gnt_s   = onehot(win_s);
                    owner_s = win_s;
                    ptr_s   = (win_s == IDW'(NUM_REQ-1)) ? '0 : win_s + IDW'(1);
                    wid_s   = nz_len(win_w_s);
                    gap_s   = nz_len(win_g_s);
                    phase_s = nz_len(win_w_s);
                    left_s  = win_c_s;
                    busy_s  = 1'b1;
                    pulse_s = (win_c_s != ZERO_C);
                end else begin
                    state_s = IDLE;
                end
            end
            HIGH: begin
                // left_r counts pulses remaining including the current one.
                if ((left_r == ZERO_C) || ((phase_r == ONE_C) && (left_r == ONE_C))) begin
                    state_s = IDLE;
                    done_s  = onehot(owner_r);
                    busy_s  = 1'b0;
                end else if (phase_r == ONE_C) begin
                    state_s = LOW;
                    phase_s = gap_r;
                    left_s  = left_r - ONE_C;
                end else begin
                    phase_s = phase_r - ONE_C;
                    pulse_s = 1'b1;
                end
            end
            LOW: begin
                if (phase_r == ONE_C) begin
                    state_s = HIGH;
                    phase_s = wid_r;
                    pulse_s = 1'b1;
                end else begin
                    phase_s = phase_r - ONE_C;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            phase_r <= '0;
            left_r  <= '0;
            wid_r   <= '0;
            gap_r   <= '0;
            ptr_r   <= '0;
            owner_r <= '0;
            gnt_r   <= '0;
            done_r  <= '0;
            busy_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            left_r  <= left_s;
            wid_r   <= wid_s;
            gap_r   <= gap_s;
            ptr_r   <= ptr_s;
            owner_r <= owner_s;
            gnt_r   <= gnt_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
            pulse_r <= pulse_s;
        end
    end

    assign gnt_o   = gnt_r;
    assign done_o  = done_r;
    assign owner_o = owner_r;
    assign busy_o  = busy_r;
    assign pulse_o = pulse_r;

endmodule

// File: tb/tb_pulse_train_scheduler.sv
// Directed self-checking bench for pulse_train_scheduler (NUM_REQ=4, CNT_W=8).
module tb_pulse_train_scheduler;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic [31:0] width;
    logic [31:0] gap;
    logic [31:0] count;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic        pulse;
    logic [3:0]  done;

    int n_tests = 0;
    int n_fail  = 0;

    pulse_train_scheduler #(.NUM_REQ(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req_i   (req),
        .width_i (width),
        .gap_i   (gap),
        .count_i (count),
        .gnt_o   (gnt),
        .owner_o (owner),
        .busy_o  (busy),
        .pulse_o (pulse),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int r, input logic [7:0] w, input logic [7:0] g, input logic [7:0] c);
        width[r*8 +: 8] = w;
        gap[r*8 +: 8]   = g;
        count[r*8 +: 8] = c;
    endtask

    task automatic do_reset();
        req  = 4'b0000;
        rstn = 1'b0;
        step();
        check_eq("rst gnt",   32'(gnt),   32'h0);
        check_eq("rst done",  32'(done),  32'h0);
        check_eq("rst busy",  32'(busy),  32'h0);
        check_eq("rst pulse", 32'(pulse), 32'h0);
        check_eq("rst owner", 32'(owner), 32'h0);
        step();
        rstn = 1'b1;
    endtask

    initial begin
        int hi_cnt;
        int done_cyc;
        rstn  = 1'b0;
        req   = 4'b0000;
        width = 32'h0;
        gap   = 32'h0;
        count = 32'h0;
        do_reset();

        // Single train W=2 G=3 C=3 on requester 0
        set_cfg(0, 8'd2, 8'd3, 8'd3);
        req = 4'b0001;
        step();
        for (int c = 0; c < 14; c++) begin
            check_eq($sformatf("single pulse c%0d", c), 32'(pulse), ((c % 5) < 2 && c < 12) ? 32'd1 : 32'd0);
            check_eq($sformatf("single busy c%0d", c),  32'(busy),  (c <= 11) ? 32'd1 : 32'd0);
            check_eq($sformatf("single done c%0d", c),  32'(done),  (c == 12) ? 32'h1 : 32'h0);
            check_eq($sformatf("single gnt c%0d", c),   32'(gnt),   (c == 0) ? 32'h1 : 32'h0);
            if (c == 0) req = 4'b0000;
            step();
        end
        check_eq("single owner hold", 32'(owner), 32'd0);

        // Contention: all four at once, W=1 C=1
        do_reset();
        for (int r = 0; r < 4; r++) set_cfg(r, 8'd1, 8'd1, 8'd1);
        req = 4'b1111;
        step();
        for (int k = 0; k < 8; k++) begin
            logic [3:0] eg;
            eg = (k % 2 == 0) ? 4'(1 << (k / 2)) : 4'b0000;
            check_eq($sformatf("cont gnt k%0d", k),   32'(gnt),   32'(eg));
            check_eq($sformatf("cont done k%0d", k),  32'(done),  (k % 2 == 1) ? 32'(1 << (k / 2)) : 32'h0);
            check_eq($sformatf("cont owner k%0d", k), 32'(owner), 32'(k / 2));
            check_eq($sformatf("cont busy k%0d", k),  32'(busy),  (k % 2 == 0) ? 32'd1 : 32'd0);
            req = req & ~eg;
            step();
        end

        // Fairness: requesters 0 and 2 held continuously
        do_reset();
        set_cfg(0, 8'd1, 8'd1, 8'd1);
        set_cfg(2, 8'd1, 8'd1, 8'd1);
        req = 4'b0101;
        step();
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) begin
                check_eq($sformatf("fair gnt k%0d", k),   32'(gnt),   ((k / 2) % 2 == 0) ? 32'h1 : 32'h4);
                check_eq($sformatf("fair owner k%0d", k), 32'(owner), ((k / 2) % 2 == 0) ? 32'd0 : 32'd2);
            end else begin
                check_eq($sformatf("fair gnt k%0d", k),  32'(gnt),  32'h0);
                check_eq($sformatf("fair done k%0d", k), 32'(done), ((k / 2) % 2 == 0) ? 32'h1 : 32'h4);
            end
            step();
        end
        req = 4'b0000;
        step();
        step();

        // Zero fields: C=0, then W=0 G=0 C=2
        do_reset();
        set_cfg(1, 8'd3, 8'd2, 8'd0);
        req = 4'b0010;
        step();
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("c0 gnt c%0d", c),   32'(gnt),   (c == 0) ? 32'h2 : 32'h0);
            check_eq($sformatf("c0 pulse c%0d", c), 32'(pulse), 32'd0);
            check_eq($sformatf("c0 busy c%0d", c),  32'(busy),  (c == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("c0 done c%0d", c),  32'(done),  (c == 1) ? 32'h2 : 32'h0);
            if (c == 0) req = 4'b0000;
            step();
        end
        set_cfg(1, 8'd0, 8'd0, 8'd2);
        req = 4'b0010;
        step();
        for (int c = 0; c < 5; c++) begin
            check_eq($sformatf("wg0 pulse c%0d", c), 32'(pulse), (c == 0 || c == 2) ? 32'd1 : 32'd0);
            check_eq($sformatf("wg0 busy c%0d", c),  32'(busy),  (c < 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("wg0 done c%0d", c),  32'(done),  (c == 3) ? 32'h2 : 32'h0);
            check_eq($sformatf("wg0 gnt c%0d", c),   32'(gnt),   (c == 0) ? 32'h2 : 32'h0);
            if (c == 0) req = 4'b0000;
            step();
        end

        // Config stability: owner's config changes mid-train
        do_reset();
        set_cfg(2, 8'd3, 8'd2, 8'd2);
        req = 4'b0100;
        step();
        for (int c = 0; c < 10; c++) begin
            check_eq($sformatf("cfg pulse c%0d", c), 32'(pulse), (c < 3 || (c >= 5 && c < 8)) ? 32'd1 : 32'd0);
            check_eq($sformatf("cfg busy c%0d", c),  32'(busy),  (c < 8) ? 32'd1 : 32'd0);
            check_eq($sformatf("cfg done c%0d", c),  32'(done),  (c == 8) ? 32'h4 : 32'h0);
            if (c == 0) begin
                req = 4'b0000;
                set_cfg(2, 8'd1, 8'd7, 8'd5);
            end
            step();
        end

        // Maximum count: W=1 G=1 C=255 lasts 509 cycles
        do_reset();
        set_cfg(3, 8'd1, 8'd1, 8'd255);
        req = 4'b1000;
        step();
        req      = 4'b0000;
        hi_cnt   = 0;
        done_cyc = -1;
        for (int c = 0; c < 512; c++) begin
            if (pulse === 1'b1) hi_cnt++;
            if (done !== 4'b0000 && done_cyc < 0) done_cyc = c;
            step();
        end
        check_eq("max pulses", 32'(hi_cnt), 32'd255);
        check_eq("max done cycle", 32'(done_cyc), 32'd509);

        // Reset mid-train during HIGH of a W=5 train
        do_reset();
        set_cfg(3, 8'd5, 8'd1, 8'd1);
        set_cfg(1, 8'd1, 8'd1, 8'd1);
        req = 4'b1000;
        step();
        check_eq("mid gnt c0", 32'(gnt), 32'h8);
        req = 4'b0000;
        step();
        step();
        check_eq("mid pulse c2", 32'(pulse), 32'd1);
        #3;
        rstn = 1'b0;
        req  = 4'b0010;
        #1;
        check_eq("mid async pulse", 32'(pulse), 32'd0);
        check_eq("mid async busy",  32'(busy),  32'd0);
        check_eq("mid async gnt",   32'(gnt),   32'h0);
        check_eq("mid async done",  32'(done),  32'h0);
        step();
        check_eq("mid held done", 32'(done), 32'h0);
        rstn = 1'b1;
        step();
        check_eq("mid regrant gnt",   32'(gnt),   32'h2);
        check_eq("mid regrant owner", 32'(owner), 32'd1);
        check_eq("mid regrant done",  32'(done),  32'h0);
        req = 4'b0000;
        step();
        check_eq("mid regrant finish", 32'(done), 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
